// File: rtl/barrel_pkg.sv
// ----------------------------------------------------------------------------
// barrel_pkg
// Shared definitions for the pipelined barrel shifter.
//   - shift mode and direction encodings as they appear on the ports
//   - per-stage control payload (valid, dir, mode) carried along with the data
//   - shift_op_e / decode_op(): folds dir + mode into one shift operation
// Configuration macro: BARREL_ROTATE_EN. When it is undefined, decode_op()
// never produces a rotate operation, so mode 10 degrades to a logical shift.
// ----------------------------------------------------------------------------
package barrel_pkg;

   localparam logic [1:0] MODE_LOG = 2'b00;
   localparam logic [1:0] MODE_ARI = 2'b01;
   localparam logic [1:0] MODE_ROT = 2'b10;

   localparam logic DIR_L = 1'b0;
   localparam logic DIR_R = 1'b1;

   // Control part of the stage payload. The data and shamt fields depend on
   // WIDTH, so they are added by the stage module around this struct.
   typedef struct packed {
      logic       valid;
      logic       dir;
      logic [1:0] mode;
   } stage_ctrl_t;

   typedef enum logic [2:0] {
      OP_SLL,   // logical left (also arithmetic left)
      OP_SRL,   // logical right
      OP_SRA,   // arithmetic right
      OP_ROL,   // rotate left
      OP_ROR    // rotate right
   } shift_op_e;

   // Reserved mode 11 and arithmetic-left both collapse onto the logical ops.
   function automatic shift_op_e decode_op(input logic dir, input logic [1:0] mode);
      shift_op_e op;
      op = (dir == DIR_R) ? OP_SRL : OP_SLL;
      if (mode == MODE_ARI && dir == DIR_R) begin
         op = OP_SRA;
      end
`ifdef BARREL_ROTATE_EN
      if (mode == MODE_ROT) begin
         op = (dir == DIR_R) ? OP_ROR : OP_ROL;
      end
`endif
      return op;
   endfunction

endpackage : barrel_pkg

// File: rtl/shift_stage.sv
// ----------------------------------------------------------------------------
// shift_stage
// One log2 stage of the pipelined barrel shifter: shifts the incoming word by
// 2^STAGE when shamt[STAGE] is set, then registers the result together with
// the shamt, direction, mode and valid bit. The register only loads when
// advance is high, so a global stall freezes every stage at once.
// Configuration macro: BARREL_ROTATE_EN adds the wrap-around term per stage.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   advance           pipeline enable (global stall when low)
//   data_d/shamt_d/
//   valid_d/dir_d/
//   mode_d            payload entering this stage
//   data_q/shamt_q/
//   valid_q/dir_q/
//   mode_q            registered payload leaving this stage
// ----------------------------------------------------------------------------
module shift_stage
   import barrel_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH),
   parameter int STAGE   = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               advance,
   input  logic [WIDTH-1:0]   data_d,
   input  logic [SHAMT_W-1:0] shamt_d,
   input  logic               valid_d,
   input  logic               dir_d,
   input  logic [1:0]         mode_d,
   output logic [WIDTH-1:0]   data_q,
   output logic [SHAMT_W-1:0] shamt_q,
   output logic               valid_q,
   output logic               dir_q,
   output logic [1:0]         mode_q
);

   localparam int AMT = 1 << STAGE;

   typedef struct packed {
      logic [WIDTH-1:0]   data;
      logic [SHAMT_W-1:0] shamt;
      stage_ctrl_t        ctrl;
   } payload_t;

   shift_op_e        op;
   logic [WIDTH-1:0] shifted;
   payload_t         payload_q;

   // Arithmetic right shifts fill from the current MSB. Every earlier stage
   // either passed the word through or did an arithmetic right shift, both
   // of which keep the MSB, so the current MSB is still the operand's sign.
   always_comb begin
      // NOTE: defaults first so every path assigns op/shifted; a missing
      // assignment on any branch would otherwise infer a latch.
      op      = decode_op(dir_d, mode_d);
      shifted = data_d;
      if (shamt_d[STAGE]) begin
         case (op)
            OP_SRL:  shifted = data_d >> AMT;
            OP_SRA:  shifted = $signed(data_d) >>> AMT;
`ifdef BARREL_ROTATE_EN
            OP_ROL:  shifted = (data_d << AMT) | (data_d >> (WIDTH - AMT));
            OP_ROR:  shifted = (data_d >> AMT) | (data_d << (WIDTH - AMT));
`endif
            default: shifted = data_d << AMT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the data field is reset as well even though it is
         // don't-care while invalid, so out_data reads 0 out of reset.
         payload_q <= '0;
      end else if (advance) begin
         // NOTE: non-blocking so every stage samples its neighbour's old value.
         payload_q <= '{data:  shifted,
                        shamt: shamt_d,
                        ctrl:  '{valid: valid_d, dir: dir_d, mode: mode_d}};
      end
   end

   assign data_q  = payload_q.data;
   assign shamt_q = payload_q.shamt;
   assign valid_q = payload_q.ctrl.valid;
   assign dir_q   = payload_q.ctrl.dir;
   assign mode_q  = payload_q.ctrl.mode;

endmodule : shift_stage

// File: rtl/pipelined_barrel_shifter.sv
// ----------------------------------------------------------------------------
// pipelined_barrel_shifter
// WIDTH-bit bidirectional barrel shifter with logical, arithmetic and rotate
// modes, built as SHAMT_W register stages (one log2 shift step per stage)
// behind a valid/ready stream interface. The whole pipeline advances together:
// when the output holds an unaccepted result, every stage holds.
// Configuration macro: BARREL_ROTATE_EN (undefined: mode 10 is a logical shift
// and no wrap-around logic is built).
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset; discards all in-flight ops
//   in_valid   operation valid
//   in_ready   operation accepted this cycle when in_valid is also high
//   in_data    operand
//   in_shamt   shift amount 0..WIDTH-1
//   in_dir     0 = left, 1 = right
//   in_mode    00 logical, 01 arithmetic, 10 rotate, 11 reserved (logical)
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_data   shifted result, held while out_valid && !out_ready
// Latency SHAMT_W cycles, throughput one op per cycle.
// ----------------------------------------------------------------------------
module pipelined_barrel_shifter
   import barrel_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic               in_dir,
   input  logic [1:0]         in_mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data
);

   logic advance;

   // Index 0 is the unregistered input; index k+1 is the register of stage k.
   logic [WIDTH-1:0]   data_pipe  [SHAMT_W+1];
   logic [SHAMT_W-1:0] shamt_pipe [SHAMT_W+1];
   logic               valid_pipe [SHAMT_W+1];
   logic               dir_pipe   [SHAMT_W+1];
   logic [1:0]         mode_pipe  [SHAMT_W+1];

   // Only the last stage can block; bubbles inside the pipe are not squeezed
   // out, so a single enable for all stages is enough.
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   // The input valid can feed stage 0 directly: whenever advance is low the
   // stage register does not load, so an unaccepted op never enters.
   assign data_pipe[0]  = in_data;
   assign shamt_pipe[0] = in_shamt;
   assign valid_pipe[0] = in_valid;
   assign dir_pipe[0]   = in_dir;
   assign mode_pipe[0]  = in_mode;

   for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
      shift_stage #(
         .WIDTH   (WIDTH),
         .SHAMT_W (SHAMT_W),
         .STAGE   (k)
      ) u_stage (
         .clk     (clk),
         .rst_n   (rst_n),
         .advance (advance),
         .data_d  (data_pipe[k]),
         .shamt_d (shamt_pipe[k]),
         .valid_d (valid_pipe[k]),
         .dir_d   (dir_pipe[k]),
         .mode_d  (mode_pipe[k]),
         .data_q  (data_pipe[k+1]),
         .shamt_q (shamt_pipe[k+1]),
         .valid_q (valid_pipe[k+1]),
         .dir_q   (dir_pipe[k+1]),
         .mode_q  (mode_pipe[k+1])
      );
   end

   assign out_valid = valid_pipe[SHAMT_W];
   assign out_data  = data_pipe[SHAMT_W];

   // A stalled result must stay put until it is taken.
   a_hold_on_stall : assert property (
      @(posedge clk) disable iff (!rst_n)
      (out_valid && !out_ready) |=> (out_valid && $stable(out_data))
   );

   // Nothing may be accepted while the output is blocked.
   a_no_accept_on_stall : assert property (
      @(posedge clk) disable iff (!rst_n)
      (out_valid && !out_ready) |-> !in_ready
   );

endmodule : pipelined_barrel_shifter

// File: tb/tb_pipelined_barrel_shifter.sv
// ----------------------------------------------------------------------------
// tb_pipelined_barrel_shifter
// Self-checking bench for pipelined_barrel_shifter at WIDTH = 8.
// Inputs change #1 after the rising edge; outputs are sampled on the falling
// edge. A scoreboard queue holds the expected result for every accepted op,
// computed bit by bit from the shift rules (or given directly for the
// directed vectors). Build with +define+BARREL_ROTATE_EN to expect rotation.
// ----------------------------------------------------------------------------
module tb_pipelined_barrel_shifter;

   localparam int WIDTH   = 8;
   localparam int SHAMT_W = 3;
`ifdef BARREL_ROTATE_EN
   localparam bit ROT_EN = 1'b1;
`else
   localparam bit ROT_EN = 1'b0;
`endif

   logic               clk;
   logic               rst_n;
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   in_data;
   logic [SHAMT_W-1:0] in_shamt;
   logic               in_dir;
   logic [1:0]         in_mode;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   out_data;

   pipelined_barrel_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_shamt  (in_shamt),
      .in_dir    (in_dir),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Reference: result bit i is picked from the operand by index arithmetic.
   function automatic logic [7:0] model(input logic [7:0] d, input int sh,
                                        input logic dir, input logic [1:0] mode);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) begin
         if (mode == 2'b10 && ROT_EN) begin
            r[i] = dir ? d[(i + sh) % 8] : d[(i - sh + 8) % 8];
         end else if (!dir) begin
            r[i] = (i >= sh) ? d[i - sh] : 1'b0;
         end else if (i + sh < 8) begin
            r[i] = d[i + sh];
         end else begin
            r[i] = (mode == 2'b01) ? d[7] : 1'b0;
         end
      end
      return r;
   endfunction

   typedef struct {
      logic [7:0] exp;
      string      tag;
   } exp_t;

   exp_t       scb[$];
   logic [7:0] cur_exp;
   bit         cur_use_exp;
   string      cur_tag;
   int         n_results = 0;
   bit         stall_seen = 1'b0;
   logic [7:0] held;

   // Monitor / scoreboard on the falling edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         scb.delete();
         stall_seen = 1'b0;
      end else begin
         if (stall_seen) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, held);
         end
         if (out_valid && !out_ready) begin
            check("in_ready_stall", in_ready, 0);
         end
         if (in_valid && in_ready) begin
            scb.push_back('{exp: cur_use_exp ? cur_exp
                                 : model(in_data, int'(in_shamt), in_dir, in_mode),
                            tag: cur_tag});
         end
         if (out_valid && out_ready) begin
            check("unexpected_result", scb.size() != 0, 1);
            if (scb.size() != 0) begin
               exp_t e;
               e = scb.pop_front();
               check(e.tag, out_data, e.exp);
               n_results++;
            end
         end
         stall_seen = out_valid && !out_ready;
         held       = out_data;
      end
   end

   task automatic send(input logic [7:0] d, input int sh, input logic dir,
                       input logic [1:0] mode, input bit use_exp,
                       input logic [7:0] exp, input string tag);
      int n;
      bit acc;
      in_data     = d;
      in_shamt    = 3'(sh);
      in_dir      = dir;
      in_mode     = mode;
      cur_exp     = exp;
      cur_use_exp = use_exp;
      cur_tag     = tag;
      in_valid    = 1'b1;
      n   = 0;
      acc = 1'b0;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = in_ready && rst_n;
         @(posedge clk);
         #1;
         n++;
      end
      if (!acc) check("send_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic send_rand(input string tag);
      send(8'($urandom), $urandom_range(0, 7), 1'($urandom), 2'($urandom), 1'b0, 8'h00, tag);
   endtask

   task automatic drain();
      int n;
      out_ready = 1'b1;
      n = 0;
      while ((scb.size() != 0 || out_valid) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("drain_empty", scb.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_latency(input string tag, input int exp_lat);
      int n;
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check(tag, n, exp_lat);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int base;
      bit done;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_shamt  = '0;
      in_dir    = 1'b0;
      in_mode   = 2'b00;
      out_ready = 1'b1;
      cur_exp   = '0;
      cur_use_exp = 1'b0;
      cur_tag   = "";

      #1;
      check("reset_out_valid", out_valid, 0);
      check("reset_out_data", out_data, 0);
      check("reset_in_ready", in_ready, 1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Logical right and first-op latency.
      send(8'h1E, 3, 1'b1, 2'b00, 1'b1, 8'h03, "t1_srl");
      wait_latency("t1_latency", SHAMT_W);
      drain();

      // Arithmetic right with sign fill, arithmetic left.
      send(8'h80, 2, 1'b1, 2'b01, 1'b1, 8'hE0, "t2_sra");
      send(8'h19, 3, 1'b0, 2'b01, 1'b1, 8'hC8, "t2_sla");
      drain();

      // Rotate (logical shift when rotate is not built).
      send(8'h81, 1, 1'b0, 2'b10, 1'b1, ROT_EN ? 8'h03 : 8'h02, "t3_rol");
      send(8'h3F, 5, 1'b1, 2'b10, 1'b1, ROT_EN ? 8'hF9 : 8'h01, "t3_ror");
      drain();

      // Zero shift passes the operand through in every mode and direction.
      for (int m = 0; m < 4; m++) begin
         for (int dr = 0; dr < 2; dr++) begin
            send(8'h5A, 0, 1'(dr), 2'(m), 1'b1, 8'h5A, "shamt0");
         end
      end
      drain();

      // Back-to-back streaming: six results on six consecutive cycles.
      base = n_results;
      fork
         begin
            for (int i = 0; i < 6; i++) send_rand("t4_stream");
         end
         begin
            n = 0;
            do begin
               @(negedge clk);
               n++;
            end while (!out_valid && n < 50);
            check("t4_first", out_valid, 1);
            for (int i = 0; i < 5; i++) begin
               @(negedge clk);
               check("t4_consecutive", out_valid, 1);
            end
         end
      join
      drain();
      check("t4_count", n_results - base, 6);

      // Backpressure right when the first result shows up.
      base = n_results;
      fork
         begin
            for (int i = 0; i < 5; i++) send_rand("t5_bp");
         end
         begin
            n = 0;
            do begin
               @(posedge clk);
               #1;
               n++;
            end while (!out_valid && n < 50);
            out_ready = 1'b0;
            #1;
            check("t5_in_ready_drop", in_ready, 0);
            repeat (5) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();
      check("t5_count", n_results - base, 5);

      // Reset with three ops in flight.
      send_rand("t6_flush");
      send_rand("t6_flush");
      send_rand("t6_flush");
      rst_n = 1'b0;
      #1;
      check("t6_async_valid", out_valid, 0);
      check("t6_async_data", out_data, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("t6_no_stale", out_valid, 0);
      end
      @(posedge clk);
      #1;
      send(8'hA5, 3, 1'b1, 2'b00, 1'b1, 8'h14, "t6_after_reset");
      wait_latency("t6_latency", SHAMT_W);
      drain();

      // Randomised traffic with random backpressure.
      base = n_results;
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 150; i++) begin
               repeat ($urandom_range(0, 2)) begin
                  @(posedge clk);
                  #1;
               end
               send_rand("rand");
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      drain();
      check("rand_count", n_results - base, 150);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_pipelined_barrel_shifter
